ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester controller that shares one single-port RAM between port 0 (instruction fetch) and port 1 (load/store).
- Sequences the RAM's chip-select/read/ready handshake and owns the bidirectional data bus.
- Round-robin fairness when both ports request.
- Sits between the core's memory ports and the ram instance.

Parameters:
- DATA_WIDTH, 16, width of data bus and requester data.
- ADDR_WIDTH, 16, width of address bus.
- TIMEOUT_CYCLES, 64, watchdog limit in clk cycles (used only with TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held high until done0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_WIDTH  port 0 address.
- wdata0  in  DATA_WIDTH  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 transaction accepted.
- done0  out  1  one-cycle pulse: port 0 transaction complete.
- rdata0  out  DATA_WIDTH  port 0 read data, valid with done0.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: identical set for port 1.
- err  out  1  pulse with doneN on timeout (tied 0 without TIMEOUT_EN).
- mem_cs  out  1  RAM chip select.
- mem_read  out  1  1 = read, 0 = write.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_data  inout  DATA_WIDTH  RAM data; driven by this block only when mem_cs=1 and mem_read=0, else high-Z.
- mem_rdy  in  1  RAM ready: idle high, drops low when RAM accepts, returns high when done.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; last-grant pointer = port 1, so port 0 wins first tie.
  - mem_cs=0, mem_read=1, mem_addr=0, mem_data=Z.
  - All gnt/done/err=0, rdata0=rdata1=0.
  - Reset mid-transaction abandons it immediately; no done pulse.
- FSM states: IDLE, ISSUE, WAIT_DONE, COMPLETE. All outputs registered.
- IDLE:
  - Only one port requesting: that port is selected.
  - Both requesting: select the port not granted last.
  - On selection: latch addr/we/wdata into internal registers; gntN=1 for the following cycle; go ISSUE.
  - Same edge: mem_cs=1, mem_read=~we, mem_addr=latched addr.
- ISSUE:
  - Hold mem_cs/mem_read/mem_addr.
  - Write: drive latched wdata on mem_data.
  - mem_rdy sampled 0 -> WAIT_DONE; otherwise stay.
- WAIT_DONE:
  - Hold all bus signals.
  - mem_rdy sampled 1 -> capture mem_data into rdataN (reads only; rdataN unchanged on writes); mem_cs=0, mem_data=Z; go COMPLETE.
- COMPLETE:
  - doneN=1 for exactly one cycle; update last-grant pointer; go IDLE.
  - A new grant occurs no earlier than the cycle after COMPLETE, giving one idle bus cycle between transactions.
- Minimum latency: req sampled to doneN = 4 cycles, given mem_rdy low one cycle after cs and high one cycle later.
- Requester inputs are ignored after latching. Dropping reqN mid-transaction does not abort it; done still pulses.
- A request arriving while busy waits. A port holding req continuously alternates with the other port, one transaction each.
- mem_data is never driven while mem_read=1, so there is no bus contention with the RAM.
- Address passes through at full ADDR_WIDTH; any RAM depth truncation is the RAM's concern.

Optional Feature:
- Macro: RAM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering ISSUE and increments in ISSUE/WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without completion: mem_cs=0, rdataN=0, go COMPLETE, pulse err with doneN.
- Not defined: no counter; the FSM waits indefinitely; err is constant 0.

Test Plan:
- Single write: reset, req1=1, we1=1, addr1=0x0010, wdata1=0xBEEF -> gnt1 one cycle; mem_cs=1, mem_read=0, mem_data=0xBEEF until mem_rdy rises; done1 one cycle; mem_data=Z after.
- Single read: req0=1, we0=0, addr0=0x0010 after above -> rdata0=0xBEEF with done0; mem_read=1 throughout; arbiter never drives mem_data.
- Contention: req0 and req1 asserted together and held for 4 transactions -> grant order 0,1,0,1; exactly one mem_cs window per transaction; at least one idle cycle between windows.
- Request drop: req0 deasserted in cycle after gnt0 -> transaction completes, done0 pulses, no second grant to port 0.
- Reset mid-op: rst_n=0 during WAIT_DONE -> mem_cs=0 and mem_data=Z the same cycle, asynchronously; no done pulse; after release, first tie goes to port 0.
- Timeout (RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_rdy held high -> at 8 cycles after ISSUE entry, mem_cs drops, done pulses with err=1, rdata=0x0000.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an instruction-fetch port
// (port 0) and a load/store port (port 1). It sequences the RAM's
// chip-select / ready handshake, owns the bidirectional data bus and
// alternates between the ports when both request.
//
// Optional feature: define RAM_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles in ISSUE/WAIT_DONE. The
// aborted transaction still completes with a done pulse, together with err.
// When the macro is undefined the FSM waits for the RAM indefinitely and err
// is tied low.
module ram_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // port 0: instruction fetch
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  done0,
    output logic [DATA_WIDTH-1:0] rdata0,
    // port 1: load/store
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata1,
    // watchdog error, pulses together with the done pulse
    output logic                  err,
    // RAM side
    output logic                  mem_cs,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_rdy
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_COMPLETE  = 2'd3;

    logic [1:0]            r_state;
    logic                  r_last;      // port granted most recently (1 = port 1)
    logic                  r_sel;       // port owning the current transaction
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_done0;
    logic                  r_done1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_mem_cs;
    logic                  r_mem_read;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic                  w_req_any;
    logic                  w_sel;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_drive;
    logic                  w_abort;     // watchdog expiry without RAM completion

    // Arbitration: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        w_req_any = req0 | req1;
        if (req0 && req1) begin
            w_sel = ~r_last;
        end else if (req1) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
        if (w_sel) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end else begin
            w_sel_we    = we0;
            w_sel_addr  = addr0;
            w_sel_wdata = wdata0;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timed_out;
    logic             r_err;
    logic             w_expired;

    // Watchdog expiry; a RAM completion in the same cycle takes precedence.
    always_comb begin
        w_expired = (r_cnt == CNT_LAST);
        if (r_state == ST_ISSUE) begin
            w_abort = w_expired;
        end else if (r_state == ST_WAIT_DONE) begin
            w_abort = w_expired & ~mem_rdy;
        end else begin
            w_abort = 1'b0;
        end
    end

    // Watchdog counter: zero while idle, counts every cycle a transaction is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Remember an abort so err can accompany the done pulse issued from COMPLETE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= (r_state == ST_COMPLETE) & r_timed_out;
            if (w_abort) begin
                r_timed_out <= 1'b1;
            end else if (r_state == ST_COMPLETE) begin
                r_timed_out <= 1'b0;
            end else begin
                r_timed_out <= r_timed_out;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_abort          = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign err              = 1'b0;
`endif

    // Transaction FSM; every requester and RAM-side output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_mem_cs   <= 1'b0;
            r_mem_read <= 1'b1;
            r_mem_addr <= '0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_sel      <= w_sel;
                        r_we       <= w_sel_we;
                        r_wdata    <= w_sel_wdata;
                        r_gnt0     <= ~w_sel;
                        r_gnt1     <= w_sel;
                        r_mem_cs   <= 1'b1;
                        r_mem_read <= ~w_sel_we;
                        r_mem_addr <= w_sel_addr;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_abort) begin
                        r_mem_cs   <= 1'b0;
                        r_mem_read <= 1'b1;
                        if (r_sel) begin
                            r_rdata1 <= '0;
                        end else begin
                            r_rdata0 <= '0;
                        end
                        r_state <= ST_COMPLETE;
                    end else if (!mem_rdy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mem_rdy) begin
                        if (!r_we) begin
                            if (r_sel) begin
                                r_rdata1 <= mem_data;
                            end else begin
                                r_rdata0 <= mem_data;
                            end
                        end
                        r_mem_cs   <= 1'b0;
                        r_mem_read <= 1'b1;
                        r_state    <= ST_COMPLETE;
                    end else if (w_abort) begin
                        r_mem_cs   <= 1'b0;
                        r_mem_read <= 1'b1;
                        if (r_sel) begin
                            r_rdata1 <= '0;
                        end else begin
                            r_rdata0 <= '0;
                        end
                        r_state <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    r_done0 <= ~r_sel;
                    r_done1 <= r_sel;
                    r_last  <= r_sel;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_cs   <= 1'b0;
                    r_mem_read <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the bus only for a write in progress; reset drops r_mem_cs and so releases it at once.
    assign w_drive  = r_mem_cs & ~r_mem_read;
    assign mem_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign mem_cs   = r_mem_cs;
    assign mem_read = r_mem_read;
    assign mem_addr = r_mem_addr;

endmodule
